// File: rtl/vga_request_controller.sv
//==============================================================================
// Module  : vga_request_controller
// Brief   : Raster timing master; issues pixel requests and re-aligns sync,
//           blanking and RGB replies onto registered VGA DAC outputs.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_request_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_LATENCY = 1
) (
  input  logic        iClk,
  input  logic        iRST,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic [11:0] oRequestX,
  output logic [11:0] oRequestY,
  output logic        oRequestValid,
  output logic        oFrameStart,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] C_H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] C_V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] C_H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] C_V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] C_HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] C_HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] C_VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] C_VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;

  // Alignment pipe: index 0 is the newest stage, PIX_LATENCY-1 the tail.
  logic [PIX_LATENCY-1:0] hs_pipe_q;
  logic [PIX_LATENCY-1:0] vs_pipe_q;
  logic [PIX_LATENCY-1:0] act_pipe_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == C_H_LAST) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == C_V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  assign w_active = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
  assign w_hs_raw = !((h_cnt_q >= C_HS_FIRST) && (h_cnt_q <= C_HS_LAST));
  assign w_vs_raw = !((v_cnt_q >= C_VS_FIRST) && (v_cnt_q <= C_VS_LAST));

  assign oRequestValid = w_active;
  assign oRequestX     = w_active ? h_cnt_q : 12'd0;
  assign oRequestY     = w_active ? v_cnt_q : 12'd0;
  assign oFrameStart   = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

  always_ff @(posedge iClk) begin
    if (iRST) begin
      h_cnt_q      <= 12'd0;
      v_cnt_q      <= 12'd0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      act_pipe_q   <= '0;
      oVGA_R       <= 8'd0;
      oVGA_G       <= 8'd0;
      oVGA_B       <= 8'd0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_pipe_q[0]  <= w_hs_raw;
      vs_pipe_q[0]  <= w_vs_raw;
      act_pipe_q[0] <= w_active;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        act_pipe_q[i] <= act_pipe_q[i-1];
      end
      // The generator reply arrives together with the pipe tail.
      oVGA_HS      <= hs_pipe_q[PIX_LATENCY-1];
      oVGA_VS      <= vs_pipe_q[PIX_LATENCY-1];
      oVGA_BLANK_N <= act_pipe_q[PIX_LATENCY-1];
      oVGA_R       <= act_pipe_q[PIX_LATENCY-1] ? iR : 8'd0;
      oVGA_G       <= act_pipe_q[PIX_LATENCY-1] ? iG : 8'd0;
      oVGA_B       <= act_pipe_q[PIX_LATENCY-1] ? iB : 8'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_request_controller.sv
//==============================================================================
// Module  : tb_vga_request_controller
// Brief   : Self-checking bench; two instances (latency 1 and 3) with a
//           reduced vertical raster, checked against an arithmetic model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_request_controller;

  localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48;
  localparam int VA = 6,   VFP = 2,  VSY = 2,  VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int GARB_START = 2 * FRAME;
  localparam int RUN_CYCLES = 2 * FRAME + 1200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] r1_i = 8'hFF, g1_i = 8'hFF, b1_i = 8'hFF;
  logic [7:0] r3_i = 8'hFF, g3_i = 8'hFF, b3_i = 8'hFF;

  logic [11:0] x1, y1, x3, y3;
  logic        v1, fs1, hs1, vs1, bl1, v3, fs3, hs3, vs3, bl3;
  logic [7:0]  r1, g1, b1, r3, g3, b3;

  int n = 0;
  bit run = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_request_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIX_LATENCY(1)
  ) dut1 (
    .iClk(clk), .iRST(rst), .iR(r1_i), .iG(g1_i), .iB(b1_i),
    .oRequestX(x1), .oRequestY(y1), .oRequestValid(v1), .oFrameStart(fs1),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
    .oVGA_HS(hs1), .oVGA_VS(vs1), .oVGA_BLANK_N(bl1)
  );

  vga_request_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIX_LATENCY(3)
  ) dut3 (
    .iClk(clk), .iRST(rst), .iR(r3_i), .iG(g3_i), .iB(b3_i),
    .oRequestX(x3), .oRequestY(y3), .oRequestValid(v3), .oFrameStart(fs3),
    .oVGA_R(r3), .oVGA_G(g3), .oVGA_B(b3),
    .oVGA_HS(hs3), .oVGA_VS(vs3), .oVGA_BLANK_N(bl3)
  );

  // Raster position of the request presented c cycles after reset release.
  function automatic int hpos(int c); return c % HT; endfunction
  function automatic int vpos(int c); return (c / HT) % VT; endfunction
  function automatic bit act(int c); return (hpos(c) < HA) && (vpos(c) < VA); endfunction

  // What the bench's generator answers to request c: echo inside the picture,
  // 0xFF garbage outside it and everywhere once the garbage phase starts.
  function automatic logic [23:0] reply(int c);
    if (c < 0 || c >= GARB_START || !act(c)) return 24'hFFFFFF;
    return {8'(hpos(c)), 8'(vpos(c)), 8'h5A};
  endfunction

  task automatic chk(string name, logic [31:0] actual, logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, actual, required);
    end
  endtask

  task automatic chk_dut(string tag, int lat, logic [11:0] x, logic [11:0] y,
                         logic v, logic fs, logic [7:0] r, logic [7:0] g,
                         logic [7:0] b, logic hs, logic vs, logic bl);
    int m;
    bit a;
    logic [23:0] rgb;
    a = act(n);
    chk({tag, "_reqX"},  32'(x),  a ? 32'(hpos(n)) : 32'd0);
    chk({tag, "_reqY"},  32'(y),  a ? 32'(vpos(n)) : 32'd0);
    chk({tag, "_valid"}, 32'(v),  32'(a));
    chk({tag, "_fstart"}, 32'(fs), 32'(hpos(n) == 0 && vpos(n) == 0));
    m = n - lat - 1;
    if (m < 0) begin
      chk({tag, "_hs"}, 32'(hs), 32'd1);
      chk({tag, "_vs"}, 32'(vs), 32'd1);
      chk({tag, "_blank_n"}, 32'(bl), 32'd0);
      chk({tag, "_rgb"}, {8'd0, r, g, b}, 32'd0);
    end else begin
      rgb = act(m) ? reply(m) : 24'd0;
      chk({tag, "_hs"}, 32'(hs),
          32'(!(hpos(m) >= HA + HFP && hpos(m) < HA + HFP + HSY)));
      chk({tag, "_vs"}, 32'(vs),
          32'(!(vpos(m) >= VA + VFP && vpos(m) < VA + VFP + VSY)));
      chk({tag, "_blank_n"}, 32'(bl), 32'(act(m)));
      chk({tag, "_rgb"}, {8'd0, r, g, b}, {8'd0, rgb});
    end
  endtask

  // Per-cycle compare against the model, plus literal pins on key cycles.
  always @(negedge clk) begin
    if (run) begin
      chk_dut("L1", 1, x1, y1, v1, fs1, r1, g1, b1, hs1, vs1, bl1);
      chk_dut("L3", 3, x3, y3, v3, fs3, r3, g3, b3, hs3, vs3, bl3);
      case (n)
        2:     begin chk("lit_l1_first_r", 32'(r1), 32'h00); chk("lit_l1_first_bl", 32'(bl1), 32'd1); end
        257:   chk("lit_l1_r255", 32'(r1), 32'hFF);
        258:   chk("lit_l1_r_wrap", 32'(r1), 32'h00);
        642:   begin chk("lit_l1_end_bl", 32'(bl1), 32'd0); chk("lit_l1_end_r", 32'(r1), 32'h00); end
        657:   chk("lit_l1_hs_pre", 32'(hs1), 32'd1);
        658:   chk("lit_l1_hs_start", 32'(hs1), 32'd0);
        753:   chk("lit_l1_hs_last", 32'(hs1), 32'd0);
        754:   chk("lit_l1_hs_end", 32'(hs1), 32'd1);
        4:     begin chk("lit_l3_first_r", 32'(r3), 32'h00); chk("lit_l3_first_bl", 32'(bl3), 32'd1); end
        643:   chk("lit_l3_last_r", 32'(r3), 32'h7F);
        644:   chk("lit_l3_end_bl", 32'(bl3), 32'd0);
        6401:  chk("lit_l1_vs_pre", 32'(vs1), 32'd1);
        6402:  chk("lit_l1_vs_start", 32'(vs1), 32'd0);
        8001:  chk("lit_l1_vs_last", 32'(vs1), 32'd0);
        8002:  chk("lit_l1_vs_end", 32'(vs1), 32'd1);
        10399: chk("lit_fs_before", 32'(fs1), 32'd0);
        10400: chk("lit_fs_frame1", 32'(fs1), 32'd1);
        20800: chk("lit_fs_frame2", 32'(fs3), 32'd1);
        default: ;
      endcase
    end
  end

  task automatic drive_replies();
    logic [23:0] a1, a3;
    a1 = reply(n - 1);
    a3 = reply(n - 3);
    {r1_i, g1_i, b1_i} = a1;
    {r3_i, g3_i, b3_i} = a3;
  endtask

  // Holds reset for three edges checking idle pins, then releases right after
  // the last reset edge so cycle 0 presents request (0,0).
  task automatic reset_and_release();
    run = 1'b0;
    rst = 1'b1;
    {r1_i, g1_i, b1_i} = 24'hFFFFFF;
    {r3_i, g3_i, b3_i} = 24'hFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      if (k == 2) begin
        #1;
        rst = 1'b0;
        n = 0;
        drive_replies();
        run = 1'b1;
      end else begin
        @(negedge clk);
        chk("rst_hs",  32'({hs1, hs3}), 32'd3);
        chk("rst_vs",  32'({vs1, vs3}), 32'd3);
        chk("rst_bl",  32'({bl1, bl3}), 32'd0);
        chk("rst_rgb", {8'd0, r1 | r3, g1 | g3, b1 | b3}, 32'd0);
        chk("rst_req", 32'({x1, y1, v1, fs1}), 32'h000003);
      end
    end
  endtask

  task automatic run_cycles(int cycles);
    for (int k = 1; k < cycles; k++) begin
      @(posedge clk);
      #1;
      n = n + 1;
      drive_replies();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    reset_and_release();
    run_cycles(700);        // stop inside the HS pulse of line 0
    reset_and_release();
    run_cycles(RUN_CYCLES);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_request_controller.md
# vga_request_controller

Display-side timing master for the projector pixel path. It sweeps a raster, issues (X, Y) pixel requests to a pattern or image generator, and receives the generator's RGB reply a fixed number of cycles later. It re-aligns sync and blanking with that reply and drives registered VGA DAC outputs. It sits between the pixel-request interface (iR/iG/iB in, oRequestX/oRequestY out) and the board's VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LATENCY, 1, cycles from request to RGB reply on iR/iG/iB; legal range 1..4

Ports:
- iClk  in  1  pixel clock
- iRST  in  1  reset; one clock; synchronous, active-high
- iR, iG, iB  in  8 each  generator reply, valid PIX_LATENCY cycles after the matching request
- oRequestX  out  12  requested column
- oRequestY  out  12  requested row
- oRequestValid  out  1  request is inside the active area
- oFrameStart  out  1  one-cycle pulse, aligned with request (0,0)
- oVGA_R, oVGA_G, oVGA_B  out  8 each  pixel data to DAC
- oVGA_HS, oVGA_VS  out  1  syncs, active-low
- oVGA_BLANK_N  out  1  high during visible pixels

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤ 4096. Counters are 12-bit unsigned.
- hCnt steps 0..H_TOTAL-1 every cycle. At H_TOTAL-1 it wraps to 0 and vCnt increments. vCnt wraps to 0 after V_TOTAL-1, when hCnt wraps.
- Region order per axis: active, front porch, sync, back porch.
- active = (hCnt < H_ACTIVE) && (vCnt < V_ACTIVE).
- Request outputs are combinational from the counter registers:
  - oRequestValid = active.
  - oRequestX/oRequestY = hCnt/vCnt when active, else 0.
- oFrameStart = (hCnt==0 && vCnt==0).
- hs_raw is low for hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] at defaults.
- vs_raw is low for vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491] at defaults. The vsync window spans whole lines, starting at hCnt=0.
- hs_raw, vs_raw and active pass through a PIX_LATENCY-deep shift register (alignment pipe).
- Output register, updated every cycle:
  - oVGA_HS/VS = pipe tail.
  - oVGA_BLANK_N = delayed active.
  - oVGA_R/G/B = iR/iG/iB when delayed active, else 0.
- There is no backpressure. The generator must answer every request in exactly PIX_LATENCY cycles. Replies outside the active area are ignored.

## Timing
- Reset (iRST high at a rising edge) takes effect on that edge:
  - hCnt = vCnt = 0.
  - Alignment pipe cleared to idle (HS=1, VS=1, active=0).
  - oVGA_R/G/B = 0, oVGA_HS = oVGA_VS = 1, oVGA_BLANK_N = 0.
  - While iRST is held, counters stay at 0, so oRequestValid = 1, oRequestX/Y = 0 and oFrameStart = 1. Downstream ignores these during reset.
- First edge after iRST falls: the counter advances to (1,0). Request (0,0) was presented during the preceding cycle.
- Request presented in cycle t reaches the VGA pins (oVGA_R/G/B, BLANK_N, HS, VS aligned) in cycle t+PIX_LATENCY+1.
- Reset mid-frame discards the in-flight pipe. No partial sync pulse survives, and outputs return to reset values on the next edge.
- At hCnt=H_TOTAL-1, vCnt=V_TOTAL-1 both counters wrap in the same edge. oFrameStart then fires again, exactly H_TOTAL*V_TOTAL cycles after the previous pulse.
- HS pulse is H_SYNC cycles wide on every line, including vertical blanking lines.

## Test plan
- Reset: hold iRST 3 cycles mid-frame, then release → during reset oVGA_HS=1, VS=1, BLANK_N=0, RGB=0. First cycle after release shows oRequestX=0, oRequestY=0, oRequestValid=1, oFrameStart=1.
- Echo model, PIX_LATENCY=1: bench returns iR=X[7:0], iG=Y[7:0], iB=0x5A one cycle after each request → line 0 pin sequence R=0,1,2,…,255,0,…, G=0, BLANK_N high for exactly 640 cycles. Pixels 640..799 show RGB=0.
- Horizontal sync: count from request (0,0) → oVGA_HS low for 96 cycles, starting at cycle 656+2 after request (0,0); repeats every 800 cycles.
- Vertical/frame wrap: run 420,000 cycles → oFrameStart pulses at cycles 0 and 420,000 only. oVGA_VS low for 1,600 cycles starting at line 490 (+2-cycle pipe offset). oRequestValid never high on lines 480..524.
- PIX_LATENCY=3 variant: echo model delayed 3 cycles → pins show R=X[7:0] at cycle request+4 with no off-by-one at line start (first visible R=0) or line end (last visible R=0x7F, pixel 639).
- Garbage rejection: drive iR/iG/iB=0xFF constantly → RGB pins read 0 whenever BLANK_N is low, including the first cycle after each active line.
